// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the byte-enable true dual-port RAM: sizing helper,
// read-during-write mode codes, clear FSM states and the byte-merge function.
package tdp_ram_pkg;

  localparam int unsigned RDW_NO_CHANGE   = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;
  localparam int unsigned RDW_WRITE_FIRST = 2;
  localparam int unsigned RDW_INVALID     = 3;

  // Widest word the byte-merge helper handles; callers size-cast in and out.
  localparam int unsigned MergeMaxW = 256;

  typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'(1) << res) < 64'(value)) res++;
    return res;
  endfunction

  function automatic int unsigned rdw_code(input string mode);
    if (mode == "NO_CHANGE") return RDW_NO_CHANGE;
    if (mode == "READ_FIRST") return RDW_READ_FIRST;
    if (mode == "WRITE_FIRST") return RDW_WRITE_FIRST;
    return RDW_INVALID;
  endfunction

  // Bit i takes new_word when its byte lane (i / byte_w) is enabled.
  function automatic logic [MergeMaxW-1:0] byte_merge(input logic [MergeMaxW-1:0] old_word,
                                                      input logic [MergeMaxW-1:0] new_word,
                                                      input logic [MergeMaxW-1:0] we,
                                                      input int unsigned byte_w);
    logic [MergeMaxW-1:0] res;
    for (int unsigned i = 0; i < MergeMaxW; i++) begin
      res[i] = we[i / byte_w] ? new_word[i] : old_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/tdp_ram_port_pipe.sv
// Per-port read response pipeline: optional array-side register for latency 2,
// then the output register that holds dout between valid strobes.
module tdp_ram_port_pipe #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid
);

  logic              stage_valid;
  logic [DATA_W-1:0] stage_data;
  logic [DATA_W-1:0] dout_q;
  logic              rvalid_q;

  if (RD_LATENCY == 2) begin : g_lat2
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;

    // Array-side register stage
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= req_valid;
        s1_data_q  <= req_data;
      end
    end

    assign stage_valid = s1_valid_q;
    assign stage_data  = s1_data_q;
  end else begin : g_lat1
    assign stage_valid = req_valid;
    assign stage_data  = req_data;
  end

  // Output register; data only moves when a response arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= stage_valid;
      if (stage_valid) dout_q <= stage_data;
    end
  end

  assign dout   = dout_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/tdp_ram_bytewe_clr.sv
// True dual-port RAM with byte write enables, selectable read-during-write
// behaviour, 1/2-cycle read latency and a built-in clear engine.
module tdp_ram_bytewe_clr
  import tdp_ram_pkg::*;
#(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       BYTE_W         = 8,
  parameter int unsigned       DEPTH          = 1024,
  parameter int unsigned       RD_LATENCY     = 2,
  parameter string             RDW_MODE       = "NO_CHANGE",
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  localparam int unsigned      NB             = DATA_W / BYTE_W,
  localparam int unsigned      ADDR_W         = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  input  logic              a_en,
  input  logic [NB-1:0]     a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic [NB-1:0]     b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_rvalid
);

  localparam int unsigned       Rdw      = rdw_code(RDW_MODE);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end
  if (Rdw == RDW_INVALID) begin : g_bad_rdw
    $error("RDW_MODE must be NO_CHANGE, READ_FIRST or WRITE_FIRST");
  end
  if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of BYTE_W");
  end

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_word,
                                              input logic [DATA_W-1:0] new_word,
                                              input logic [NB-1:0]     we);
    return DATA_W'(byte_merge(MergeMaxW'(old_word), MergeMaxW'(new_word), MergeMaxW'(we),
                              BYTE_W));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              rst_q;

  logic              a_acc, b_acc, a_in, b_in, a_wr, b_wr, collide;
  logic [DATA_W-1:0] a_old, b_old, a_wword, b_wword;
  logic              a_resp_valid, b_resp_valid;
  logic [DATA_W-1:0] a_resp_data, b_resp_data;

  // Port acceptance, collision merge and same-cycle response selection
  always_comb begin
    a_acc   = a_en & ~busy & ~rst;
    b_acc   = b_en & ~busy & ~rst;
    a_in    = 32'(a_addr) < DEPTH;
    b_in    = 32'(b_addr) < DEPTH;
    a_old   = a_in ? mem[a_addr] : CLEAR_VALUE;
    b_old   = b_in ? mem[b_addr] : CLEAR_VALUE;
    a_wr    = a_acc & (|a_we) & a_in;
    b_wr    = b_acc & (|b_we) & b_in;
    collide = a_wr & b_wr & (a_addr == b_addr);
    a_wword = merge(a_old, a_din, a_we);
    b_wword = merge(b_old, b_din, b_we);
    // Both ports land on one word: B's bytes first, A overrides shared lanes
    if (collide) begin
      a_wword = merge(b_wword, a_din, a_we);
      b_wword = a_wword;
    end
    a_resp_valid = a_acc & ((a_we == '0) | (Rdw != RDW_NO_CHANGE));
    b_resp_valid = b_acc & ((b_we == '0) | (Rdw != RDW_NO_CHANGE));
    a_resp_data  = ((a_we == '0) | (Rdw == RDW_READ_FIRST)) ? a_old : a_wword;
    b_resp_data  = ((b_we == '0) | (Rdw == RDW_READ_FIRST)) ? b_old : b_wword;
  end

  // Array writes; the clear engine owns the array while busy
  always_ff @(posedge clk) begin
    if (busy) begin
      if (!rst) mem[clr_addr_q] <= CLEAR_VALUE;
    end else begin
      if (b_wr) mem[b_addr] <= b_wword;
      if (a_wr) mem[a_addr] <= a_wword;
    end
  end

  // Remember the previous reset level to spot its falling edge
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Clear FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Clear FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (clr_start || (rst_q && CLEAR_ON_RESET)) state_d = StClear;
      StClear: if (clr_addr_q == LastAddr) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    busy     = (state_q == StClear);
    clr_done = busy && (clr_addr_q == LastAddr);
  end

  // Clear address counter, wraps to 0 for the next clear
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_q <= '0;
    end else if (state_q == StClear) begin
      clr_addr_q <= (clr_addr_q == LastAddr) ? '0 : clr_addr_q + 1'b1;
    end
  end

  tdp_ram_port_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (a_resp_valid),
    .req_data  (a_resp_data),
    .dout      (a_dout),
    .rvalid    (a_rvalid)
  );

  tdp_ram_port_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_resp_valid),
    .req_data  (b_resp_data),
    .dout      (b_dout),
    .rvalid    (b_rvalid)
  );

endmodule

// File: tb/tb_tdp_ram_bytewe_clr.sv
// Bench: three RAM variants share one stimulus stream and are checked every
// cycle against a per-variant behavioural model, plus directed table rows.
//   dut0: NO_CHANGE,   latency 2, clear on reset
//   dut1: READ_FIRST,  latency 1, no clear on reset
//   dut2: WRITE_FIRST, latency 2, clear on reset
module tb_tdp_ram_bytewe_clr;

  localparam int D  = 16;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst, clr_start;
  logic        a_en, b_en;
  logic [1:0]  a_we, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic        busy_o [NI];
  logic        done_o [NI];
  logic [15:0] a_dout_o [NI];
  logic [15:0] b_dout_o [NI];
  logic        a_rv_o [NI];
  logic        b_rv_o [NI];

  always #5 clk = ~clk;

  tdp_ram_bytewe_clr #(.DATA_W(16), .BYTE_W(8), .DEPTH(D), .RD_LATENCY(2),
    .RDW_MODE("NO_CHANGE"), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h0000)) u_dut0 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy_o[0]), .clr_done(done_o[0]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_o[0]),
    .a_rvalid(a_rv_o[0]), .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout_o[0]), .b_rvalid(b_rv_o[0]));

  tdp_ram_bytewe_clr #(.DATA_W(16), .BYTE_W(8), .DEPTH(D), .RD_LATENCY(1),
    .RDW_MODE("READ_FIRST"), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(16'h0000)) u_dut1 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy_o[1]), .clr_done(done_o[1]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_o[1]),
    .a_rvalid(a_rv_o[1]), .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout_o[1]), .b_rvalid(b_rv_o[1]));

  tdp_ram_bytewe_clr #(.DATA_W(16), .BYTE_W(8), .DEPTH(D), .RD_LATENCY(2),
    .RDW_MODE("WRITE_FIRST"), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h0000)) u_dut2 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy_o[2]), .clr_done(done_o[2]),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_o[2]),
    .a_rvalid(a_rv_o[2]), .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout_o[2]), .b_rvalid(b_rv_o[2]));

  // 0 = no change, 1 = read first, 2 = write first
  function automatic int mode_of(int k); return k; endfunction
  function automatic int lat_of(int k); return (k == 1) ? 1 : 2; endfunction
  function automatic bit cor_of(int k); return k != 1; endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          k;
    int          due;
    bit          port;
    logic [15:0] data;
  } resp_t;

  logic [15:0] mm [NI][D];
  int          clr_left [NI];
  int          clr_idx [NI];
  bit          prev_rst [NI];
  bit          e_busy [NI], e_done [NI], e_arv [NI], e_brv [NI];
  logic [15:0] e_ad [NI], e_bd [NI];
  resp_t       rq [$];
  int          ncyc;
  int          nvec, nfail;

  function automatic logic [15:0] wmerge(logic [15:0] o, logic [15:0] n, logic [1:0] we);
    logic [15:0] r;
    r = o;
    for (int b = 0; b < 2; b++) if (we[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic respond(int k, bit port, bit wr, logic [15:0] old_w, logic [15:0] new_w);
    resp_t r;
    if (wr && mode_of(k) == 0) return;
    r.k    = k;
    r.port = port;
    r.due  = ncyc + lat_of(k) - 1;
    r.data = (!wr || mode_of(k) == 1) ? old_w : new_w;
    rq.push_back(r);
  endtask

  task automatic port_model(int k);
    logic [15:0] oa, ob, wa, wb;
    bit          wra, wrb;
    oa  = mm[k][a_addr];
    ob  = mm[k][b_addr];
    wra = a_en && (a_we != 2'b00);
    wrb = b_en && (b_we != 2'b00);
    wa  = wmerge(oa, a_din, a_we);
    wb  = wmerge(ob, b_din, b_we);
    if (wra && wrb && a_addr == b_addr) begin
      wa = wmerge(wmerge(oa, b_din, b_we), a_din, a_we);
      wb = wa;
    end
    if (a_en) respond(k, 1'b0, wra, oa, wa);
    if (b_en) respond(k, 1'b1, wrb, ob, wb);
    if (wrb) mm[k][b_addr] = wb;
    if (wra) mm[k][a_addr] = wa;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    ncyc++;
    for (int k = 0; k < NI; k++) begin
      bit busy_pre;
      busy_pre = clr_left[k] != 0;
      e_arv[k] = 1'b0;
      e_brv[k] = 1'b0;
      if (rst) begin
        clr_left[k] = 0;
        clr_idx[k]  = 0;
        prev_rst[k] = 1'b1;
        e_ad[k]     = 16'h0;
        e_bd[k]     = 16'h0;
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].k == k) rq.delete(i);
      end else begin
        if (!busy_pre) port_model(k);
        if (busy_pre) begin
          mm[k][clr_idx[k]] = 16'h0;
          clr_idx[k]++;
          clr_left[k]--;
        end else if (clr_start || (prev_rst[k] && cor_of(k))) begin
          clr_left[k] = D;
          clr_idx[k]  = 0;
        end
        prev_rst[k] = 1'b0;
        for (int i = rq.size() - 1; i >= 0; i--) begin
          if (rq[i].k == k && rq[i].due == ncyc) begin
            if (rq[i].port) begin e_brv[k] = 1'b1; e_bd[k] = rq[i].data; end
            else            begin e_arv[k] = 1'b1; e_ad[k] = rq[i].data; end
            rq.delete(i);
          end
        end
      end
      e_busy[k] = clr_left[k] != 0;
      e_done[k] = clr_left[k] == 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(int k, string nm, logic [15:0] act, logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", nm, k, ncyc, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk(k, "busy", 16'(busy_o[k]), 16'(e_busy[k]));
      chk(k, "clr_done", 16'(done_o[k]), 16'(e_done[k]));
      chk(k, "a_rvalid", 16'(a_rv_o[k]), 16'(e_arv[k]));
      chk(k, "b_rvalid", 16'(b_rv_o[k]), 16'(e_brv[k]));
      chk(k, "a_dout", a_dout_o[k], e_ad[k]);
      chk(k, "b_dout", b_dout_o[k], e_bd[k]);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    clr_start = 1'b0;
    a_en = 1'b0; a_we = 2'b00; a_addr = 4'd0; a_din = 16'h0;
    b_en = 1'b0; b_we = 2'b00; b_addr = 4'd0; b_din = 16'h0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          ae; logic [1:0] awe; logic [3:0] aa; logic [15:0] ad;
    bit          be; logic [1:0] bwe; logic [3:0] ba; logic [15:0] bd;
    bit          ca; logic [15:0] xa;
    bit          cb; logic [15:0] xb;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int bcnt, dcnt;
    nvec = 0; nfail = 0; ncyc = 0;
    for (int k = 0; k < NI; k++) begin
      clr_left[k] = 0; clr_idx[k] = 0; prev_rst[k] = 1'b0;
      e_ad[k] = 16'h0; e_bd[k] = 16'h0;
      for (int i = 0; i < D; i++) mm[k][i] = 16'h0;
    end

    tbl[0]  = '{1, 2'b11, 4'd5, 16'hBEEF, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 0, 16'h0000};
    tbl[1]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 2'b00, 4'd5, 16'h0000, 0, 16'h0000, 1, 16'hBEEF};
    tbl[2]  = '{1, 2'b11, 4'd3, 16'h1234, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 0, 16'h0000};
    tbl[3]  = '{1, 2'b10, 4'd3, 16'hAB00, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 0, 16'h0000};
    tbl[4]  = '{1, 2'b00, 4'd3, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 1, 16'hAB34, 0, 16'h0000};
    tbl[5]  = '{1, 2'b10, 4'd7, 16'h1100, 1, 2'b11, 4'd7, 16'h2222, 0, 16'h0000, 0, 16'h0000};
    tbl[6]  = '{1, 2'b00, 4'd7, 16'h0000, 1, 2'b00, 4'd5, 16'h0000, 1, 16'h1122, 1, 16'hBEEF};
    tbl[7]  = '{1, 2'b11, 4'd2, 16'h0001, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 0, 16'h0000};
    tbl[8]  = '{1, 2'b01, 4'd4, 16'h55AA, 1, 2'b00, 4'd4, 16'h0000, 0, 16'h0000, 1, 16'h0000};
    tbl[9]  = '{1, 2'b00, 4'd4, 16'h0000, 1, 2'b00, 4'd7, 16'h0000, 1, 16'h00AA, 1, 16'h1122};
    tbl[10] = '{1, 2'b00, 4'd9, 16'h0000, 1, 2'b01, 4'd9, 16'hCAFE, 1, 16'h0000, 0, 16'h0000};
    tbl[11] = '{1, 2'b00, 4'd3, 16'h0000, 1, 2'b00, 4'd9, 16'h0000, 1, 16'hAB34, 1, 16'h00FE};

    // Reset state
    idle();
    rst = 1'b1;
    repeat (3) cycle();

    // Auto-clear after reset: dut0 busy for exactly D cycles, one clr_done
    rst = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (busy_o[0]) bcnt++;
      if (done_o[0]) dcnt++;
    end
    chk(0, "reset_clear_busy_cycles", 16'(bcnt), 16'(D));
    chk(0, "reset_clear_done_pulses", 16'(dcnt), 16'd1);

    // Explicit clear so every variant starts from a known array
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    repeat (D + 2) cycle();

    // Read back every address on both ports
    for (int i = 0; i < D; i++) begin
      a_en = 1'b1; a_addr = 4'(i);
      b_en = 1'b1; b_addr = 4'(D - 1 - i);
      cycle();
    end
    idle();
    repeat (2) cycle();

    // Table rows: one access cycle, one idle cycle, then dut0's response
    for (int r = 0; r < 12; r++) begin
      a_en = tbl[r].ae; a_we = tbl[r].awe; a_addr = tbl[r].aa; a_din = tbl[r].ad;
      b_en = tbl[r].be; b_we = tbl[r].bwe; b_addr = tbl[r].ba; b_din = tbl[r].bd;
      cycle();
      idle();
      cycle();
      if (tbl[r].ca) chk(0, $sformatf("tbl%0d_a_dout", r), a_dout_o[0], tbl[r].xa);
      if (tbl[r].cb) chk(0, $sformatf("tbl%0d_b_dout", r), b_dout_o[0], tbl[r].xb);
    end

    // Write to addr 2 (holds 0x0001) under each read-during-write mode
    a_en = 1'b1; a_we = 2'b11; a_addr = 4'd2; a_din = 16'h0002;
    cycle();
    chk(1, "rf_rvalid", 16'(a_rv_o[1]), 16'd1);
    chk(1, "rf_dout", a_dout_o[1], 16'h0001);
    idle();
    cycle();
    chk(0, "nc_rvalid", 16'(a_rv_o[0]), 16'd0);
    chk(0, "nc_dout_held", a_dout_o[0], 16'hAB34);
    chk(2, "wf_rvalid", 16'(a_rv_o[2]), 16'd1);
    chk(2, "wf_dout", a_dout_o[2], 16'h0002);

    // Randomized traffic with occasional clears
    for (int n = 0; n < 600; n++) begin
      clr_start = ($urandom_range(0, 79) == 0);
      a_en   = ($urandom_range(0, 9) < 7);
      a_we   = $urandom_range(0, 1) ? 2'($urandom) : 2'b00;
      a_addr = 4'($urandom_range(0, 15));
      a_din  = 16'($urandom);
      b_en   = ($urandom_range(0, 9) < 7);
      b_we   = $urandom_range(0, 1) ? 2'($urandom) : 2'b00;
      b_addr = ($urandom_range(0, 3) == 0) ? a_addr : 4'($urandom_range(0, 15));
      b_din  = 16'($urandom);
      cycle();
    end
    idle();
    repeat (D + 4) cycle();

    // Fill, then abort a clear with reset at clr_addr 6
    for (int i = 0; i < D; i++) begin
      a_en = 1'b1; a_we = 2'b11; a_addr = 4'(i); a_din = 16'hA0A0 + 16'(i);
      cycle();
    end
    idle();
    repeat (2) cycle();
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    repeat (6) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk(1, "abort_busy_low", 16'(busy_o[1]), 16'd0);
    chk(0, "abort_restart_busy", 16'(busy_o[0]), 16'd1);
    dcnt = 0;
    for (int i = 0; i < D + 4; i++) begin
      cycle();
      if (done_o[1]) dcnt++;
    end
    chk(1, "abort_no_done", 16'(dcnt), 16'd0);
    for (int i = 0; i < D; i++) begin
      a_en = 1'b1; a_we = 2'b00; a_addr = 4'(i);
      cycle();
      if (i >= 6) chk(1, $sformatf("abort_keep_%0d", i), a_dout_o[1], 16'hA0A0 + 16'(i));
      else        chk(1, $sformatf("abort_zero_%0d", i), a_dout_o[1], 16'h0000);
    end
    idle();
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/tdp_ram_bytewe_clr.md
# tdp_ram_bytewe_clr

Single-clock, parametrised true dual-port block RAM for the accelerator's feature-map and weight buffers. Adds three things to the basic dual-port buffer: byte-granular write enables, a selectable read-during-write mode, and a read latency of 1 or 2 with aligned valid strobes. A built-in clear engine fills the whole array with a constant after reset or on request, so layer buffers are zeroed without host traffic.

## Interface
- DATA_W, 16: word width; must be a multiple of BYTE_W.
- BYTE_W, 8: write-enable granularity; NB = DATA_W/BYTE_W.
- DEPTH, 1024: number of words; ADDR_W = max(1, clog2(DEPTH)).
- RD_LATENCY, 2: 1 or 2; any other value is a compile-time error.
- RDW_MODE, "NO_CHANGE": "NO_CHANGE", "READ_FIRST" or "WRITE_FIRST"; applies to both ports.
- CLEAR_ON_RESET, 1: 1 starts a clear automatically when rst deasserts.
- CLEAR_VALUE, 0: DATA_W-wide fill word.
- clk in 1: single clock for both ports.
- rst in 1: synchronous, active-high; clears pipelines and outputs, not array contents.
- clr_start in 1: one-cycle request to fill the array with CLEAR_VALUE.
- busy out 1: high while the clear runs; both ports are then ignored.
- clr_done out 1: one-cycle pulse in the cycle the last word is written.
- a_en, b_en in 1: port access request.
- a_we, b_we in NB: byte write enables; all-zero means a read.
- a_addr, b_addr in ADDR_W: word address.
- a_din, b_din in DATA_W: write data.
- a_dout, b_dout out DATA_W: read data; holds its value between valid strobes.
- a_rvalid, b_rvalid out 1: a_dout/b_dout carries the response for the access issued RD_LATENCY cycles earlier.

## Operation
- An access is accepted when x_en=1 and busy=0. Accesses offered while busy=1 are dropped: no write and no rvalid.
- A write updates only the bytes whose x_we bit is set.
- Read (x_we==0): the word is returned after RD_LATENCY cycles with x_rvalid=1.
- Write, by RDW_MODE:
  - NO_CHANGE: no rvalid, and dout keeps its previous value.
  - READ_FIRST: rvalid=1; dout carries the pre-write word.
  - WRITE_FIRST: rvalid=1; dout carries the post-write merged word.
- Same-address writes on both ports in one cycle: merged per byte; port A wins any byte enabled on both.
- Same-address read on one port while the other port writes: the read returns the pre-write word, in every mode.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_start, or on the first cycle after rst deasserts when CLEAR_ON_RESET=1.
  - In CLEAR, counter clr_addr runs 0..DEPTH-1 and writes CLEAR_VALUE, one word per cycle.
  - CLEAR -> IDLE after writing word DEPTH-1; clr_done pulses in that cycle.
- clr_start while busy is ignored.
- rst during CLEAR aborts it. The clear restarts from address 0 afterwards only if CLEAR_ON_RESET=1.
- Address arithmetic is unsigned ADDR_W-bit. Addresses >= DEPTH (non-power-of-2 DEPTH) are ignored for writes and return CLEAR_VALUE for reads.

## Timing
- Reset values: a_dout = b_dout = 0, a_rvalid = b_rvalid = 0, busy = 0, clr_done = 0. The FSM resets to IDLE and the clear counter to 0.
- RD_LATENCY=1: access in cycle t -> dout/rvalid in cycle t+1. RD_LATENCY=2 -> cycle t+2 (array register plus output register).
- Back-to-back accesses are allowed every cycle on both ports; throughput is 1 access/port/cycle.
- busy goes high the cycle after the triggering event (clr_start, or rst deassertion with CLEAR_ON_RESET=1). It stays high for exactly DEPTH cycles and falls the cycle after clr_done.
- Accesses accepted in the cycle before busy rises complete normally.
- Write-to-read on the same address from either port: data is visible to a read issued one cycle after the write.

## Structure
- Shared package tdp_ram_pkg holds:
  - the clog2 function;
  - localparam encodings RDW_NO_CHANGE=0, RDW_READ_FIRST=1, RDW_WRITE_FIRST=2, plus a string-to-code function;
  - a byte-merge function (old, new, we) -> word.
- Sub-module tdp_ram_port_pipe is instantiated once per port. It holds the latency-1/2 data and valid pipeline, the dout hold and the reset behaviour.
- The array, the collision merge and the clear FSM stay in the top module.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> busy high for 16 cycles, clr_done pulses once; reading all addresses then returns 0x0000.
- Port A writes 0xBEEF to addr 5 with we=2'b11, then port B reads addr 5 -> b_dout=0xBEEF with b_rvalid two cycles after the read (RD_LATENCY=2).
- Addr 3 holds 0x1234; port A writes 0xAB00 with we=2'b10 -> a later read gives 0xAB34.
- Both ports write addr 7 in one cycle: A writes 0x1100 with we=2'b10, B writes 0x2222 with we=2'b11 -> addr 7 reads 0x1122.
- READ_FIRST, addr 2 holds 0x0001: A writes 0x0002 -> a_rvalid=1 with a_dout=0x0001. The same stimulus in NO_CHANGE gives no rvalid and a_dout unchanged.
- Assert clr_start, then rst mid-clear at clr_addr=6 with CLEAR_ON_RESET=0 -> busy=0, no clr_done pulse, and addresses >= 6 keep their old data.
